// File: rtl/viterbi_link_sequencer.sv
// Frame sequencer for the encoder/channel/Viterbi test link: PRBS payload, periodic symbol corruption,
// decoder-output error counting. chan_o/dec_en_o follow their inputs by one cycle; no backpressure.
module viterbi_link_sequencer #(
  parameter int unsigned N         = 4,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned TAIL      = 8,
  parameter int unsigned DEC_LAT   = 40,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        err_en_i,
  input  logic [1:0]  err_mask_i,
  output logic        enc_data_o,
  output logic        enc_en_o,
  input  logic        enc_valid_i,
  input  logic [1:0]  chan_i,
  output logic [1:0]  chan_o,
  output logic        dec_en_o,
  input  logic        dec_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [15:0]  LAST_BIT   = 16'(FRAME_LEN - 1);
  localparam logic [15:0]  TAIL_END   = 16'(TAIL);
  localparam logic [15:0]  LAST_FLUSH = 16'(TAIL + DEC_LAT - 1);
  localparam logic [N-1:0] INJ_PHASE  = '1;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]         flush_cnt_q, flush_cnt_d;
  logic [15:0]         bit_err_q, bit_err_d;
  logic [15:0]         inj_q, inj_d;
  logic [1:0]          chan_q;
  logic                dec_en_q;
  logic [DEC_LAT-1:0]  dly_bit_q, dly_flag_q;
  logic [DEC_LAT:0]    bit_shift, flag_shift;
  logic                enc_data, enc_en, payload, inj, mismatch;

  assign bit_shift  = {dly_bit_q, enc_data};
  assign flag_shift = {dly_flag_q, payload};
  // Only bits that were payload when sent are scored; flush bits carry flag 0.
  assign mismatch   = dly_flag_q[DEC_LAT-1] && (dly_bit_q[DEC_LAT-1] != dec_data_i);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    bit_err_d   = bit_err_q;
    inj_d       = inj_q;
    enc_en      = 1'b0;
    enc_data    = 1'b0;
    payload     = 1'b0;
    inj         = 1'b0;

    if (mismatch && (bit_err_q != 16'hFFFF)) bit_err_d = bit_err_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RUN;
          lfsr_d    = SEED;
          bit_cnt_d = '0;
          bit_err_d = '0;
          inj_d     = '0;
        end
      end
      S_RUN: begin
        enc_en    = 1'b1;
        enc_data  = lfsr_q[0];
        payload   = 1'b1;
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        bit_cnt_d = bit_cnt_q + 16'd1;
        inj       = err_en_i && (bit_cnt_q[N-1:0] == INJ_PHASE);
        if (inj && (inj_q != 16'hFFFF)) inj_d = inj_q + 16'd1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        // Zero tail drives the encoder home, then idle long enough to drain the decoder.
        enc_en      = (flush_cnt_q < TAIL_END);
        flush_cnt_d = flush_cnt_q + 16'd1;
        if (flush_cnt_q == LAST_FLUSH) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      bit_err_q   <= '0;
      inj_q       <= '0;
      chan_q      <= '0;
      dec_en_q    <= 1'b0;
      dly_bit_q   <= '0;
      dly_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      bit_err_q   <= bit_err_d;
      inj_q       <= inj_d;
      chan_q      <= chan_i ^ (inj ? err_mask_i : 2'b00);
      dec_en_q    <= enc_valid_i;
      dly_bit_q   <= bit_shift[DEC_LAT-1:0];
      dly_flag_q  <= flag_shift[DEC_LAT-1:0];
    end
  end

  assign enc_data_o   = enc_data;
  assign enc_en_o     = enc_en;
  assign chan_o       = chan_q;
  assign dec_en_o     = dec_en_q;
  assign busy_o       = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done_o       = (state_q == S_DONE);
  assign bit_err_ct_o = bit_err_q;
  assign inj_ct_o     = inj_q;
endmodule

// File: tb/tb_viterbi_link_sequencer.sv
// Bench for viterbi_link_sequencer: per-cycle scoreboard on channel/encoder outputs plus frame-level scenario tasks.
module tb_viterbi_link_sequencer;
  localparam int N     = 4;
  localparam int FL    = 256;
  localparam int TAIL  = 8;
  localparam int DL    = 40;
  localparam int DONEC = FL + TAIL + DL + 1;
  localparam int SFL   = 65535;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed { logic b; logic pay; logic [15:0] idx; } hist_t;

  logic clk = 1'b0, rst = 1'b0;
  logic start_i = 1'b0, err_en_i = 1'b0, enc_valid_i = 1'b0, dec_data_i = 1'b0;
  logic [1:0] err_mask_i = 2'b00, chan_i = 2'b00;
  logic enc_data_o, enc_en_o, dec_en_o, busy_o, done_o;
  logic [1:0] chan_o;
  logic [15:0] bit_err_ct_o, inj_ct_o;

  logic s_start = 1'b0, s_dec_data_i = 1'b0;
  logic s_enc_data, s_enc_en, s_dec_en, s_busy, s_done;
  logic [1:0] s_chan;
  logic [15:0] s_bit_err, s_inj;

  int checks = 0, passes = 0, cyc = 0, fc = 0, dec_mode = 0, flip0 = 0, flip1 = 0;
  logic [15:0] lfsr_m = SEED, run_bits = '0;
  hist_t hist[$];
  logic [1:0] exp_chan_q[$];
  logic exp_den_q[$];
  hist_t hd;
  logic flip, exp_en, exp_d, inj_m, exp_v, prev_ok = 1'b0;
  logic [1:0] exp_c, prev_chan = 2'b00;
  logic [DL:0] s_h = '0;

  always #5 clk = ~clk;

  viterbi_link_sequencer #(.N(N), .FRAME_LEN(FL), .TAIL(TAIL), .DEC_LAT(DL), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .err_en_i(err_en_i), .err_mask_i(err_mask_i),
    .enc_data_o(enc_data_o), .enc_en_o(enc_en_o), .enc_valid_i(enc_valid_i), .chan_i(chan_i),
    .chan_o(chan_o), .dec_en_o(dec_en_o), .dec_data_i(dec_data_i), .busy_o(busy_o),
    .done_o(done_o), .bit_err_ct_o(bit_err_ct_o), .inj_ct_o(inj_ct_o));

  viterbi_link_sequencer #(.N(N), .FRAME_LEN(SFL), .TAIL(TAIL), .DEC_LAT(DL), .SEED(SEED)) u_sat (
    .clk(clk), .rst(rst), .start_i(s_start), .err_en_i(1'b0), .err_mask_i(2'b00),
    .enc_data_o(s_enc_data), .enc_en_o(s_enc_en), .enc_valid_i(enc_valid_i), .chan_i(chan_i),
    .chan_o(s_chan), .dec_en_o(s_dec_en), .dec_data_i(s_dec_data_i), .busy_o(s_busy),
    .done_o(s_done), .bit_err_ct_o(s_bit_err), .inj_ct_o(s_inj));

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Frame model, decoder model and channel/encoder scoreboard, one pass per cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) fc = 0;
      else if (fc == 0) begin
        if (start_i) begin fc = 1; lfsr_m = SEED; end
      end else begin
        if (fc <= FL) lfsr_m = lfsr_step(lfsr_m);
        fc = (fc == DONEC) ? 0 : fc + 1;
      end
      #1;
      if (!rst) begin
        hist.delete(); exp_chan_q.delete(); exp_den_q.delete();
        prev_ok = 1'b0; dec_data_i = 1'b0; s_dec_data_i = 1'b0;
      end else begin
        exp_en = (fc >= 1) && (fc <= FL + TAIL);
        exp_d  = (fc >= 1 && fc <= FL) ? lfsr_m[0] : 1'b0;
        checks++;
        if ({enc_en_o, enc_data_o} !== {exp_en, exp_d})
          $display("FAIL enc_out cyc %0d: got en,data=%b%b expected %b%b", cyc, enc_en_o, enc_data_o, exp_en, exp_d);
        else passes++;
        if (exp_chan_q.size() > 0) begin
          exp_c = exp_chan_q.pop_front();
          checks++;
          if (chan_o !== exp_c) $display("FAIL chan_o cyc %0d: got %b expected %b", cyc, chan_o, exp_c);
          else passes++;
        end
        if (exp_den_q.size() > 0) begin
          exp_v = exp_den_q.pop_front();
          checks++;
          if (dec_en_o !== exp_v) $display("FAIL dec_en_o cyc %0d: got %b expected %b", cyc, dec_en_o, exp_v);
          else passes++;
        end
        if (prev_ok) begin
          flip0 += int'(chan_o[0] != prev_chan[0]);
          flip1 += int'(chan_o[1] != prev_chan[1]);
        end
        if (fc >= 1 && fc <= 16) run_bits[fc-1] = enc_data_o;
        hist.push_front('{b: enc_data_o, pay: (fc >= 1 && fc <= FL), idx: 16'(fc - 1)});
        if (hist.size() > DL + 1) void'(hist.pop_back());
        if (hist.size() == DL + 1) begin
          hd = hist[DL];
          case (dec_mode)
            1:       flip = hd.pay && (hd.idx == 16'd0 || hd.idx == 16'd100 || hd.idx == 16'd255);
            2:       flip = !hd.pay;
            default: flip = 1'b0;
          endcase
          dec_data_i = hd.b ^ flip;
        end else dec_data_i = 1'b0;
        s_h = {s_h[DL-1:0], s_enc_data};
        s_dec_data_i = ~s_h[DL];
        chan_i = 2'($urandom);
        enc_valid_i = 1'($urandom);
        inj_m = (fc >= 1) && (fc <= FL) && err_en_i && (((fc - 1) % (1 << N)) == (1 << N) - 1);
        exp_chan_q.push_back(chan_i ^ (inj_m ? err_mask_i : 2'b00));
        exp_den_q.push_back(enc_valid_i);
        prev_chan = chan_i;
        prev_ok = 1'b1;
      end
    end
  end

  task automatic kick(output int s);
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int s, input int budget, output int lat, output bit got);
    got = 1'b0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_o) begin got = 1'b1; lat = cyc - s; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #3;
    checks++; if ({enc_en_o, enc_data_o} !== 2'b00) $display("FAIL rst_enc: got %b expected 00", {enc_en_o, enc_data_o}); else passes++;
    checks++; if (chan_o !== 2'b00) $display("FAIL rst_chan: got %b expected 00", chan_o); else passes++;
    checks++; if (dec_en_o !== 1'b0) $display("FAIL rst_dec_en: got %b expected 0", dec_en_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else passes++;
    checks++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b expected 0", done_o); else passes++;
    checks++; if (bit_err_ct_o !== 16'd0) $display("FAIL rst_bit_err: got %0d expected 0", bit_err_ct_o); else passes++;
    checks++; if (inj_ct_o !== 16'd0) $display("FAIL rst_inj: got %0d expected 0", inj_ct_o); else passes++;
    @(posedge clk); #5 rst = 1'b1;
  endtask

  task automatic test_basic();
    int s, lat; bit got;
    err_en_i = 1'b0; dec_mode = 0;
    kick(s);
    checks++; if (busy_o !== 1'b1) $display("FAIL busy_cycle1: got %b expected 1", busy_o); else passes++;
    wait_done(s, 400, lat, got);
    checks++; if (!got || lat != DONEC - 1) $display("FAIL done_cycle: got %0d (seen %0d) expected %0d", lat + 1, got, DONEC); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL busy_at_done: got %b expected 0", busy_o); else passes++;
    checks++; if (bit_err_ct_o !== 16'd0) $display("FAIL basic_bit_err: got %0d expected 0", bit_err_ct_o); else passes++;
    checks++; if (inj_ct_o !== 16'd0) $display("FAIL basic_inj: got %0d expected 0", inj_ct_o); else passes++;
  endtask

  task automatic test_inject();
    int s, lat; bit got;
    err_en_i = 1'b1; err_mask_i = 2'b01; flip0 = 0; flip1 = 0;
    kick(s); wait_done(s, 400, lat, got);
    checks++; if (!got || inj_ct_o !== 16'd16) $display("FAIL inj_count: got %0d expected 16", inj_ct_o); else passes++;
    checks++; if (flip0 != 16) $display("FAIL inj_flip0: got %0d expected 16", flip0); else passes++;
    checks++; if (flip1 != 0) $display("FAIL inj_flip1: got %0d expected 0", flip1); else passes++;
    err_mask_i = 2'b00; flip0 = 0; flip1 = 0;
    kick(s); wait_done(s, 400, lat, got);
    checks++; if (!got || inj_ct_o !== 16'd16) $display("FAIL inj_zero_mask_count: got %0d expected 16", inj_ct_o); else passes++;
    checks++; if (flip0 + flip1 != 0) $display("FAIL inj_zero_mask_flips: got %0d expected 0", flip0 + flip1); else passes++;
    err_en_i = 1'b0;
  endtask

  task automatic test_dec_errors();
    int s, lat; bit got;
    dec_mode = 1;
    kick(s); wait_done(s, 400, lat, got);
    checks++; if (!got || bit_err_ct_o !== 16'd3) $display("FAIL dec_payload_errs: got %0d expected 3", bit_err_ct_o); else passes++;
    dec_mode = 2;
    kick(s); wait_done(s, 400, lat, got);
    checks++; if (!got || bit_err_ct_o !== 16'd0) $display("FAIL dec_tail_errs: got %0d expected 0", bit_err_ct_o); else passes++;
    dec_mode = 0;
  endtask

  task automatic test_back_to_back();
    int s, lat; bit got;
    logic [15:0] a, b, m, l;
    l = SEED;
    for (int i = 0; i < 16; i++) begin m[i] = l[0]; l = lfsr_step(l); end
    dec_mode = 1; err_en_i = 1'b1; err_mask_i = 2'b10;
    kick(s); wait_done(s, 400, lat, got);
    a = run_bits;
    checks++; if (bit_err_ct_o !== 16'd3 || inj_ct_o !== 16'd16) $display("FAIL b2b_first_counts: got %0d/%0d expected 3/16", bit_err_ct_o, inj_ct_o); else passes++;
    dec_mode = 0; err_en_i = 1'b0;
    kick(s);
    checks++; if (bit_err_ct_o !== 16'd0 || inj_ct_o !== 16'd0) $display("FAIL b2b_clear: got %0d/%0d expected 0/0", bit_err_ct_o, inj_ct_o); else passes++;
    wait_done(s, 400, lat, got);
    b = run_bits;
    checks++; if (!got || a !== b) $display("FAIL b2b_repeat: got %h expected %h", b, a); else passes++;
    checks++; if (a !== m) $display("FAIL b2b_lfsr: got %h expected %h", a, m); else passes++;
  endtask

  task automatic test_ignore_start();
    int s, lat, dones, busy_ct; bit got;
    kick(s);
    repeat (49) @(posedge clk);
    #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    wait_done(s, 400, lat, got);
    checks++; if (!got || lat != DONEC - 1) $display("FAIL start_in_run: got %0d expected %0d", lat + 1, DONEC); else passes++;
    start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    dones = 0; busy_ct = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      dones += int'(done_o); busy_ct += int'(busy_o);
    end
    checks++; if (dones != 0) $display("FAIL start_in_done_dones: got %0d expected 0", dones); else passes++;
    checks++; if (busy_ct != 0) $display("FAIL start_in_done_busy: got %0d expected 0", busy_ct); else passes++;
  endtask

  task automatic test_reset_mid();
    int s, dones, busy_ct;
    err_en_i = 1'b1; err_mask_i = 2'b11;
    kick(s);
    repeat (99) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if ({enc_en_o, enc_data_o, chan_o, dec_en_o} !== 5'b0) $display("FAIL midrst_outs: got %b expected 00000", {enc_en_o, enc_data_o, chan_o, dec_en_o}); else passes++;
    checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL midrst_status: got %b expected 00", {busy_o, done_o}); else passes++;
    checks++; if (bit_err_ct_o !== 16'd0 || inj_ct_o !== 16'd0) $display("FAIL midrst_counts: got %0d/%0d expected 0/0", bit_err_ct_o, inj_ct_o); else passes++;
    repeat (2) @(posedge clk);
    #5 rst = 1'b1;
    err_en_i = 1'b0;
    dones = 0; busy_ct = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      dones += int'(done_o); busy_ct += int'(busy_o);
    end
    checks++; if (dones != 0 || busy_ct != 0) $display("FAIL midrst_no_done: got done %0d busy %0d expected 0 0", dones, busy_ct); else passes++;
  endtask

  task automatic test_saturation();
    bit got;
    @(posedge clk); #2 s_start = 1'b1;
    @(posedge clk); #2 s_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #2;
      if (s_done) begin got = 1'b1; break; end
    end
    checks++; if (!got) $display("FAIL sat_done: got no done expected done"); else passes++;
    checks++; if (s_bit_err !== 16'hFFFF) $display("FAIL sat_bit_err: got %h expected ffff", s_bit_err); else passes++;
    checks++; if (s_inj !== 16'd0 || s_busy !== 1'b0) $display("FAIL sat_inj_busy: got %0d/%b expected 0/0", s_inj, s_busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inject();
    test_dec_errors();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
